max_scan_ctrl: RTL and testbench
================================

Name: max_scan_ctrl

Overview:
- Sequencer and arbiter for the shared max-search datapath. The datapath is a BRAM max-compare engine: 8-bit read address, 16-bit data, unsigned running maximum, synchronous clear.
- Accepts scan jobs (start address, length) from two requesters and grants one at a time, round-robin.
- Drives the engine's count/startaddr/sreset inputs, waits out the read-pipeline latency, then returns the captured maximum to the owning requester.

Parameters:
- AW, 8, engine address width
- DW, 16, data/maximum width
- RD_LAT, 1, BRAM read latency in cycles; the drain length is RD_LAT+1

Ports:
- mclk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  2  per-requester job request, level; held until that requester's done
- start0  in  16  requester 0 start address
- len0  in  9  requester 0 word count, 0..256
- start1  in  16  requester 1 start address
- len1  in  9  requester 1 word count, 0..256
- eng_startaddr  out  16  to engine startaddr
- eng_count  out  8  to engine count
- eng_sreset  out  1  to engine sreset
- eng_max  in  16  engine running max
- busy  out  1  job in progress
- grant  out  2  one-hot owner of the current job
- done  out  2  one-hot, 1-cycle completion pulse
- result  out  16  max of the last completed job; valid from the done cycle

Behaviour:
- Interface fact: reset reset, synchronous, active-high; clock mclk.
- Reset values: state=IDLE, eng_count=0, eng_sreset=1, eng_startaddr=0, busy=0, grant=0, done=0, result=0, rr_ptr=0.
- Job latching:
  - On grant, the owner's start and len are latched into internal registers.
  - Later changes to the start/len inputs are ignored until the next grant.
- States:
  - IDLE
    - eng_sreset=1, busy=0.
    - If any req bit is set: pick the requester by rr_ptr priority (rr_ptr=0 favours req[0]), set grant, latch the job.
    - If latched len==0 go to DONE; otherwise go to CLEAR.
  - CLEAR (1 cycle)
    - eng_sreset=1, eng_count=0.
    - Next state SCAN.
  - SCAN
    - eng_sreset=0, eng_count increments by one each cycle, 0..len-1.
    - When eng_count==len-1 (len-1 computed in 9 bits; len=256 reaches count 255), go to DRAIN.
  - DRAIN (RD_LAT+1 cycles)
    - eng_count holds at len-1, eng_sreset=0.
    - Re-reading the same address is harmless.
    - Next state DONE.
  - DONE (1 cycle)
    - result<=eng_max (len==0: result<=0).
    - done[owner]=1; grant and busy clear at the end of this cycle.
    - rr_ptr<=~owner. Next state IDLE.
- Cycle count: from grant to done is len+RD_LAT+3 cycles for len>0, and 1 cycle for len==0.
- Address wrap: the engine truncates startaddr+count to AW bits, so scans wrap modulo 256. The controller does not check for wrap.
- Word 0: engine addra is 0 during clear, so mem[0] enters the first compare. System rule: mem word 0 is reserved and held at 0x0000; unsigned compare then never raises max.
- Back-to-back: a new grant may be issued in the IDLE cycle right after DONE. Every job passes through CLEAR, so there is no carry-over of max.
- Requester dropping req mid-job: the job still completes and done is still pulsed.
- Simultaneous req: both set in IDLE → the rr_ptr favourite wins; the other waits exactly one job.
- Reset mid-job: the job is abandoned, no done is issued, and all outputs return to reset values on the next edge.
- busy=1 in CLEAR, SCAN, DRAIN and DONE.

Decomposition:
- Shared package max_scan_pkg:
  - state enum (IDLE, CLEAR, SCAN, DRAIN, DONE)
  - AW/DW defaults
  - constant NUM_REQ=2
- Sub-module rr_arbiter2: 2-way round-robin, one-hot grant, pointer update on an enable pulse. Instantiated once.
- The FSM, counter and result register live in max_scan_ctrl.

Test Plan:
- Single job: req0, start0=0x10, len0=4, mem[0x10..0x13]=3,9,2,7 → eng_count 0,1,2,3; done=2'b01 exactly 8 cycles after grant (RD_LAT=1); result=9.
- Contention: req=2'b11 from reset → requester 0 served first, then requester 1 without an idle gap beyond one IDLE cycle; third simultaneous round serves requester 1 first.
- Full length with wrap: start1=0xF0, len1=256, mem[0x05]=0xFFFF (all other words 0x0100) → count reaches 255, eng_count never exceeds 255, result=0xFFFF, done=2'b10.
- Zero length: len0=0 → done one cycle after grant, result=0, eng_sreset stays 1 throughout.
- Reset mid-scan: assert reset while eng_count=5 of len=20 → no done pulse, busy=0 and eng_sreset=1 next cycle; a new job afterwards returns the correct max with no stale value.
- Input change after grant: alter start0/len0 while SCAN → scan uses the originally latched values; result is unchanged.

Source files
------------

// File: rtl/max_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// max_scan_pkg : shared types and constants for the max-search scan controller
// Rev 1.0
// ============================================================================
package max_scan_pkg;

    localparam int DEF_AW  = 8;
    localparam int DEF_DW  = 16;
    localparam int SW      = 16;
    localparam int NUM_REQ = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/max_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// max_scan_ctrl_if : requester-side job bus and engine-side control bundle
// Rev 1.0
// ============================================================================
interface max_scan_ctrl_if #(
    parameter int AW = max_scan_pkg::DEF_AW,
    parameter int DW = max_scan_pkg::DEF_DW
);
    import max_scan_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [SW-1:0]      start0;
    logic [AW:0]        len0;
    logic [SW-1:0]      start1;
    logic [AW:0]        len1;
    logic [SW-1:0]      eng_startaddr;
    logic [AW-1:0]      eng_count;
    logic               eng_sreset;
    logic [DW-1:0]      eng_max;
    logic               busy;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] done;
    logic [DW-1:0]      result;

    modport slave (
        input  req, start0, len0, start1, len1, eng_max,
        output eng_startaddr, eng_count, eng_sreset, busy, grant, done, result
    );

    modport master (
        output req, start0, len0, start1, len1, eng_max,
        input  eng_startaddr, eng_count, eng_sreset, busy, grant, done, result
    );

endinterface
`default_nettype wire

// File: rtl/max_scan_ctrl_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// rr_arbiter2 : two-way round-robin arbiter, pointer advances on adv pulse
// Rev 1.0
// ============================================================================
module rr_arbiter2 (
    input  wire logic       mclk,
    input  wire logic       reset,
    input  wire logic [1:0] req,
    input  wire logic       adv,
    input  wire logic [1:0] last,
    output logic      [1:0] gnt
);

    logic rr_ptr;

    always_comb begin
        gnt = 2'b00;
        if (!rr_ptr) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end else begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end
    end

    // The pointer moves to favour whoever did not just finish.
    always_ff @(posedge mclk) begin
        if (reset)    rr_ptr <= 1'b0;
        else if (adv) rr_ptr <= ~last[1];
    end

endmodule
`default_nettype wire

// File: rtl/max_scan_ctrl.sv
`default_nettype none
// ============================================================================
// max_scan_ctrl : arbitrates two scan requesters and sequences the max engine
// Rev 1.0
// ============================================================================
module max_scan_ctrl
    import max_scan_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int RD_LAT = 1
) (
    input  wire logic       mclk,
    input  wire logic       reset,
    max_scan_ctrl_if.slave  bus
);

    localparam int DRW = $clog2(RD_LAT + 2);

    state_t             state;
    state_t             state_nxt;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [NUM_REQ-1:0] owner;
    logic [SW-1:0]      job_start;
    logic [AW:0]        job_len;
    logic [AW-1:0]      count;
    logic [DRW-1:0]     drain_cnt;
    logic [DW-1:0]      result_q;
    logic [SW-1:0]      sel_start;
    logic [AW:0]        sel_len;
    logic [AW:0]        len_m1;
    logic               take_job;
    logic               scan_last;
    logic               drain_last;

    rr_arbiter2 u_arb (
        .mclk  (mclk),
        .reset (reset),
        .req   (bus.req),
        .adv   (state == ST_DONE),
        .last  (owner),
        .gnt   (arb_gnt)
    );

    assign sel_start  = arb_gnt[1] ? bus.start1 : bus.start0;
    assign sel_len    = arb_gnt[1] ? bus.len1   : bus.len0;
    assign take_job   = (state == ST_IDLE) && (arb_gnt != 2'b00) && !reset;
    assign len_m1     = job_len - 1'b1;
    assign scan_last  = ({1'b0, count} == len_m1);
    assign drain_last = (drain_cnt == DRW'(RD_LAT));

    always_ff @(posedge mclk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (take_job) state_nxt = (sel_len == '0) ? ST_DONE : ST_CLEAR;
            ST_CLEAR: state_nxt = ST_SCAN;
            ST_SCAN:  if (scan_last) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.grant      = (state == ST_IDLE) ? (reset ? 2'b00 : arb_gnt) : owner;
        bus.done       = (state == ST_DONE) ? owner : 2'b00;
        bus.busy       = (state != ST_IDLE);
        bus.eng_sreset = !((state == ST_SCAN) || (state == ST_DRAIN));
    end

    // Result is captured on entry to DONE so it is already valid with the done pulse.
    always_ff @(posedge mclk) begin
        if (reset) begin
            owner     <= '0;
            job_start <= '0;
            job_len   <= '0;
            count     <= '0;
            drain_cnt <= '0;
            result_q  <= '0;
        end else begin
            if (take_job) begin
                owner     <= arb_gnt;
                job_start <= sel_start;
                job_len   <= sel_len;
            end else if (state == ST_DONE) begin
                owner <= '0;
            end

            case (state)
                ST_SCAN:  if (!scan_last) count <= count + 1'b1;
                ST_DRAIN: count <= count;
                default:  count <= '0;
            endcase

            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;

            if (take_job && (sel_len == '0))
                result_q <= '0;
            else if ((state == ST_DRAIN) && drain_last)
                result_q <= bus.eng_max;
        end
    end

    assign bus.eng_startaddr = job_start;
    assign bus.eng_count     = count;
    assign bus.result        = result_q;

endmodule
`default_nettype wire

// File: tb/tb_max_scan_ctrl.sv
`default_nettype none
// ============================================================================
// tb_max_scan_ctrl : directed bench with a behavioural BRAM max engine
// Rev 1.0
// ============================================================================
module tb_max_scan_ctrl;

    logic        mclk = 1'b0;
    logic        reset;
    logic [15:0] mem [256];
    logic [15:0] eng_dout;
    logic [7:0]  eng_addr;
    int          checks = 0;
    int          errors = 0;
    int          cnt_log[$];

    max_scan_ctrl_if #(.AW(8), .DW(16)) bus ();

    max_scan_ctrl #(.AW(8), .DW(16), .RD_LAT(1)) dut (
        .mclk  (mclk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 mclk = ~mclk;

    // Engine: address 0 while cleared, one-cycle read, unsigned running max.
    always_comb eng_addr = bus.eng_sreset ? 8'h00 : 8'(bus.eng_startaddr + 16'(bus.eng_count));

    always @(posedge mclk) begin
        eng_dout    <= mem[eng_addr];
        bus.eng_max <= bus.eng_sreset ? 16'h0000 : ((eng_dout > bus.eng_max) ? eng_dout : bus.eng_max);
    end

    task automatic tick;
        @(posedge mclk);
        #1;
    endtask

    task automatic fill_mem(input logic [15:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
        mem[0] = 16'h0000;
    endtask

    task automatic do_reset;
        reset   = 1'b1;
        bus.req = 2'b00;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic run_to_done(input int limit, output int cyc);
        cyc = 0;
        cnt_log.delete();
        while (bus.done === 2'b00 && cyc < limit) begin
            tick();
            cyc++;
            if (bus.eng_sreset === 1'b0) cnt_log.push_back(int'(bus.eng_count));
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; bus.req = 2'b00;
        repeat (2) tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
        checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", bus.grant); end
        checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL reset_done got %b exp 00", bus.done); end
        checks++; if (bus.eng_sreset !== 1'b1) begin errors++; $display("FAIL reset_sreset got %0b exp 1", bus.eng_sreset); end
        checks++; if (bus.eng_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.eng_count); end
        checks++; if (bus.eng_startaddr !== 16'h0) begin errors++; $display("FAIL reset_startaddr got %h exp 0", bus.eng_startaddr); end
        checks++; if (bus.result !== 16'h0) begin errors++; $display("FAIL reset_result got %h exp 0", bus.result); end
        reset = 1'b0;
    endtask

    task automatic test_single;
        int cyc;
        int exp_cnt[6] = '{0, 1, 2, 3, 3, 3};
        do_reset();
        fill_mem(16'h0000);
        mem[8'h10] = 16'd3; mem[8'h11] = 16'd9; mem[8'h12] = 16'd2; mem[8'h13] = 16'd7;
        bus.start0 = 16'h0010; bus.len0 = 9'd4; bus.req = 2'b01;
        #1;
        checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", bus.grant); end
        run_to_done(50, cyc);
        checks++; if (bus.done !== 2'b01) begin errors++; $display("FAIL single_done got %b exp 01", bus.done); end
        checks++; if (cyc !== 8) begin errors++; $display("FAIL single_latency got %0d exp 8", cyc); end
        checks++; if (bus.result !== 16'd9) begin errors++; $display("FAIL single_result got %h exp 0009", bus.result); end
        checks++; if (cnt_log.size() !== 6) begin errors++; $display("FAIL single_count_len got %0d exp 6", cnt_log.size()); end
        for (int i = 0; i < 6 && i < cnt_log.size(); i++) begin
            checks++; if (cnt_log[i] !== exp_cnt[i]) begin errors++; $display("FAIL single_count[%0d] got %0d exp %0d", i, cnt_log[i], exp_cnt[i]); end
        end
        bus.req = 2'b00;
        tick();
        checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL single_done_pulse got %b exp 00", bus.done); end
        checks++; if (bus.busy !== 1'b0 || bus.grant !== 2'b00) begin errors++; $display("FAIL single_idle got busy=%0b grant=%b exp 0/00", bus.busy, bus.grant); end
    endtask

    task automatic test_zero_length;
        bus.start0 = 16'h0080; bus.len0 = 9'd0; bus.req = 2'b01;
        #1;
        checks++; if (bus.grant !== 2'b01 || bus.eng_sreset !== 1'b1) begin errors++; $display("FAIL zero_grant got grant=%b sreset=%0b exp 01/1", bus.grant, bus.eng_sreset); end
        tick();
        checks++; if (bus.done !== 2'b01) begin errors++; $display("FAIL zero_done got %b exp 01", bus.done); end
        checks++; if (bus.result !== 16'h0) begin errors++; $display("FAIL zero_result got %h exp 0000", bus.result); end
        checks++; if (bus.eng_sreset !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL zero_done_cycle got sreset=%0b busy=%0b exp 1/1", bus.eng_sreset, bus.busy); end
        bus.req = 2'b00;
        tick();
        checks++; if (bus.done !== 2'b00 || bus.eng_sreset !== 1'b1) begin errors++; $display("FAIL zero_after got done=%b sreset=%0b exp 00/1", bus.done, bus.eng_sreset); end
    endtask

    task automatic test_contention;
        int cyc;
        logic [1:0]  exp_own[3] = '{2'b01, 2'b10, 2'b01};
        logic [15:0] exp_res[3] = '{16'd5, 16'd8, 16'd5};
        do_reset();
        fill_mem(16'h0000);
        mem[8'h20] = 16'd5; mem[8'h21] = 16'd4;
        mem[8'h30] = 16'd1; mem[8'h31] = 16'd8; mem[8'h32] = 16'd6;
        bus.start0 = 16'h0020; bus.len0 = 9'd2;
        bus.start1 = 16'h0030; bus.len1 = 9'd3;
        bus.req = 2'b11;
        #1;
        checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL cont_first_grant got %b exp 01", bus.grant); end
        for (int j = 0; j < 3; j++) begin
            run_to_done(50, cyc);
            checks++; if (bus.done !== exp_own[j]) begin errors++; $display("FAIL cont_done[%0d] got %b exp %b", j, bus.done, exp_own[j]); end
            checks++; if (bus.result !== exp_res[j]) begin errors++; $display("FAIL cont_result[%0d] got %h exp %h", j, bus.result, exp_res[j]); end
            if (j < 2) begin
                tick();
                checks++; if (bus.grant !== exp_own[j+1] || bus.busy !== 1'b0) begin errors++; $display("FAIL cont_regrant[%0d] got grant=%b busy=%0b exp %b/0", j, bus.grant, bus.busy, exp_own[j+1]); end
            end
        end
        bus.req = 2'b00;
        tick();
        bus.req = 2'b11;
        #1;
        checks++; if (bus.grant !== 2'b10) begin errors++; $display("FAIL cont_round3_grant got %b exp 10", bus.grant); end
        run_to_done(50, cyc);
        checks++; if (bus.done !== 2'b10 || bus.result !== 16'd8) begin errors++; $display("FAIL cont_round3 got done=%b result=%h exp 10/0008", bus.done, bus.result); end
        bus.req = 2'b00;
        tick();
    endtask

    task automatic test_wrap;
        int cyc;
        int mx;
        do_reset();
        fill_mem(16'h0100);
        mem[8'h05] = 16'hFFFF;
        bus.start1 = 16'h00F0; bus.len1 = 9'd256; bus.req = 2'b10;
        #1;
        run_to_done(400, cyc);
        mx = 0;
        foreach (cnt_log[i]) if (cnt_log[i] > mx) mx = cnt_log[i];
        checks++; if (bus.done !== 2'b10) begin errors++; $display("FAIL wrap_done got %b exp 10", bus.done); end
        checks++; if (bus.result !== 16'hFFFF) begin errors++; $display("FAIL wrap_result got %h exp FFFF", bus.result); end
        checks++; if (cyc !== 260) begin errors++; $display("FAIL wrap_latency got %0d exp 260", cyc); end
        checks++; if (mx !== 255 || cnt_log.size() !== 258) begin errors++; $display("FAIL wrap_count got max=%0d n=%0d exp 255/258", mx, cnt_log.size()); end
        bus.req = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid_scan;
        int cyc;
        do_reset();
        fill_mem(16'h0000);
        for (int i = 0; i < 20; i++) mem[8'h40 + i] = 16'(i + 1);
        bus.start0 = 16'h0040; bus.len0 = 9'd20; bus.req = 2'b01;
        cyc = 0;
        while (!(bus.eng_sreset === 1'b0 && bus.eng_count === 8'd5) && cyc < 50) begin
            tick();
            cyc++;
        end
        checks++; if (cyc >= 50) begin errors++; $display("FAIL midrst_reach got cycles=%0d exp <50", cyc); end
        reset = 1'b1;
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.eng_sreset !== 1'b1) begin errors++; $display("FAIL midrst_state got busy=%0b sreset=%0b exp 0/1", bus.busy, bus.eng_sreset); end
        checks++; if (bus.done !== 2'b00 || bus.grant !== 2'b00) begin errors++; $display("FAIL midrst_outputs got done=%b grant=%b exp 00/00", bus.done, bus.grant); end
        checks++; if (bus.eng_count !== 8'd0 || bus.result !== 16'h0) begin errors++; $display("FAIL midrst_regs got count=%0d result=%h exp 0/0000", bus.eng_count, bus.result); end
        bus.len0 = 9'd3;
        mem[8'h40] = 16'd1; mem[8'h41] = 16'd2; mem[8'h42] = 16'd1;
        reset = 1'b0;
        #1;
        run_to_done(50, cyc);
        checks++; if (bus.done !== 2'b01 || bus.result !== 16'd2) begin errors++; $display("FAIL midrst_rerun got done=%b result=%h exp 01/0002", bus.done, bus.result); end
        checks++; if (cyc !== 7) begin errors++; $display("FAIL midrst_latency got %0d exp 7", cyc); end
        bus.req = 2'b00;
        tick();
    endtask

    task automatic test_input_change;
        int cyc;
        do_reset();
        fill_mem(16'h0000);
        mem[8'h60] = 16'd4; mem[8'h61] = 16'h0011; mem[8'h62] = 16'd6; mem[8'h63] = 16'd1;
        mem[8'h70] = 16'hAAAA;
        bus.start0 = 16'h0060; bus.len0 = 9'd4; bus.req = 2'b01;
        #1;
        repeat (3) tick();
        bus.start0 = 16'h0070; bus.len0 = 9'd1;
        #1;
        checks++; if (bus.eng_startaddr !== 16'h0060) begin errors++; $display("FAIL chg_startaddr got %h exp 0060", bus.eng_startaddr); end
        run_to_done(50, cyc);
        checks++; if (bus.result !== 16'h0011 || bus.done !== 2'b01) begin errors++; $display("FAIL chg_result got result=%h done=%b exp 0011/01", bus.result, bus.done); end
        checks++; if (cyc + 3 !== 8) begin errors++; $display("FAIL chg_latency got %0d exp 8", cyc + 3); end
        bus.req = 2'b00;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        bus.req = 2'b00;
        bus.start0 = '0; bus.len0 = '0;
        bus.start1 = '0; bus.len1 = '0;
        bus.eng_max = '0;
        eng_dout = '0;
        fill_mem(16'h0000);
        test_reset();
        test_single();
        test_zero_length();
        test_contention();
        test_wrap();
        test_reset_mid_scan();
        test_input_change();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
`default_nettype wire
